// File: rtl/demux_stream_pkg.sv
// demux_stream_pkg: shared route FSM state type and skid depth for demux_stream_router
package demux_stream_pkg;
  typedef enum logic [1:0] {IDLE, PKT0, PKT1} route_state_t;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/demux_stream_router_skid_buffer.sv
// skid_buffer: 2-entry registered skid buffer (in_valid/in_ready/in_data -> out_valid/out_ready/out_data), in_ready comes only from a flop
module skid_buffer
  import demux_stream_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] head, tail;
  logic [1:0] cnt, cnt_n;
  logic nf, push, pop;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign cnt_n = cnt + {1'b0, push} - {1'b0, pop};
  assign in_ready = nf;
  assign out_valid = cnt != 2'd0;
  assign out_data = head;
  // nf reflects occupancy after this edge, so in_ready never sees out_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      nf <= 1'b1;
    end else begin
      cnt <= cnt_n;
      nf <= cnt_n < 2'(SKID_DEPTH);
      if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) head <= in_data;
      else if (pop && cnt == 2'd2) head <= tail;
      if (push && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop))) tail <= in_data;
    end
  end
endmodule

// File: rtl/demux_stream_router.sv
// demux_stream_router: 1-to-2 packet demux with first-beat select lock, per-channel skid buffers and packet counters
// ports: s_* input stream (valid/ready/data/sel/last), m0_*/m1_* output streams, pkt_cnt0/1 completed packets, busy = packet open
module demux_stream_router
  import demux_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sel,
  input  logic              s_last,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_last,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_last,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              busy
);
  route_state_t state;
  logic tgt, rdy0, rdy1, acc;
  // s_sel only matters while no packet is open
  assign tgt = (state == PKT1) | ((state == IDLE) & s_sel);
  assign s_ready = ~rst & (tgt ? rdy1 : rdy0);
  assign acc = s_valid & s_ready;
  assign busy = state != IDLE;
  skid_buffer #(.W(DATA_W + 1)) u_ch0 (
    .clk(clk), .rst(rst),
    .in_valid(acc & ~tgt), .in_ready(rdy0), .in_data({s_last, s_data}),
    .out_valid(m0_valid), .out_ready(m0_ready), .out_data({m0_last, m0_data})
  );
  skid_buffer #(.W(DATA_W + 1)) u_ch1 (
    .clk(clk), .rst(rst),
    .in_valid(acc & tgt), .in_ready(rdy1), .in_data({s_last, s_data}),
    .out_valid(m1_valid), .out_ready(m1_ready), .out_data({m1_last, m1_data})
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (acc) begin
      state <= s_last ? IDLE : (state == IDLE ? (s_sel ? PKT1 : PKT0) : state);
      if (s_last && !tgt) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (s_last && tgt) pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_stream_router.sv
// tb_demux_stream_router: directed and random checks of demux_stream_router against a queue-based packet model
module tb_demux_stream_router;
  logic clk = 0, rst = 1;
  logic s_valid = 0, s_ready, s_sel = 0, s_last = 0;
  logic [7:0] s_data = 0;
  logic m0_valid, m0_ready = 0, m0_last, m1_valid, m1_ready = 0, m1_last;
  logic [7:0] m0_data, m1_data;
  logic [3:0] pkt_cnt0, pkt_cnt1;
  logic busy;
  int passed = 0, total = 0;
  logic [8:0] q0[$], q1[$];
  bit open_pkt = 0, open_tgt = 0;
  int cnt0 = 0, cnt1 = 0;

  demux_stream_router #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sel(s_sel), .s_last(s_last), .m0_valid(m0_valid), .m0_ready(m0_ready),
    .m0_data(m0_data), .m0_last(m0_last), .m1_valid(m1_valid), .m1_ready(m1_ready),
    .m1_data(m1_data), .m1_last(m1_last), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    bit t = open_pkt ? open_tgt : s_sel;
    return !rst && (t ? q1.size() < 2 : q0.size() < 2);
  endfunction

  // Compare all outputs against the model mid-cycle, then advance the model across the edge
  task automatic step();
    bit t, rdy, p0, p1;
    @(negedge clk);
    rdy = model_ready();
    chk("s_ready", s_ready, rdy);
    chk("m0_valid", m0_valid, q0.size() > 0);
    chk("m1_valid", m1_valid, q1.size() > 0);
    if (q0.size() > 0) chk("m0_beat", {m0_last, m0_data}, q0[0]);
    if (q1.size() > 0) chk("m1_beat", {m1_last, m1_data}, q1[0]);
    chk("pkt_cnt0", pkt_cnt0, cnt0 % 16);
    chk("pkt_cnt1", pkt_cnt1, cnt1 % 16);
    chk("busy", busy, open_pkt);
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete(); open_pkt = 0; cnt0 = 0; cnt1 = 0;
    end else begin
      t = open_pkt ? open_tgt : s_sel;
      p0 = q0.size() > 0 && m0_ready;
      p1 = q1.size() > 0 && m1_ready;
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (s_valid && rdy) begin
        if (t) q1.push_back({s_last, s_data}); else q0.push_back({s_last, s_data});
        if (s_last) begin
          open_pkt = 0;
          if (t) cnt1++; else cnt0++;
        end else begin
          open_pkt = 1; open_tgt = t;
        end
      end
    end
    #1;
  endtask

  task automatic beat(bit v, bit sel, bit last, logic [7:0] d);
    s_valid = v; s_sel = sel; s_last = last; s_data = d;
    step();
  endtask

  initial begin
    // reset held 3 cycles with s_valid high
    s_valid = 1; s_sel = 1; s_last = 1; s_data = 8'h5a;
    @(posedge clk); #1;
    repeat (3) step();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m0_valid", m0_valid, 0);
    chk("rst_cnt0", pkt_cnt0, 0);
    rst = 0; s_valid = 0;
    #1 chk("post_rst_s_ready", s_ready, 1);

    // select lock: sel toggles on beats 2-3, whole packet goes to ch1
    m1_ready = 1; m0_ready = 1;
    beat(1, 1, 0, 8'h11);
    chk("lock_busy1", busy, 1);
    chk("lock_m1_d1", m1_data, 8'h11);
    beat(1, 0, 0, 8'h22);
    chk("lock_busy2", busy, 1);
    chk("lock_m1_d2", m1_data, 8'h22);
    beat(1, 1, 1, 8'h33);
    chk("lock_busy3", busy, 0);
    chk("lock_m1_d3", {m1_valid, m1_last, m1_data}, {2'b11, 8'h33});
    chk("lock_m0_valid", m0_valid, 0);
    chk("lock_cnt1", pkt_cnt1, 1);
    beat(0, 0, 0, 8'h00);

    // backpressure on ch0
    m0_ready = 0;
    beat(1, 0, 1, 8'ha1);
    beat(1, 0, 1, 8'ha2);
    beat(1, 0, 1, 8'ha3);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_m0_data", m0_data, 8'ha1);
    beat(1, 0, 1, 8'ha3);
    chk("bp_m0_hold", m0_data, 8'ha1);
    m0_ready = 1;
    for (int i = 0; i < 5; i++) beat(q0.size() < 3 && cnt0 < 3 ? 1'b1 : 1'b0, 0, 1, 8'ha3);
    chk("bp_cnt0", pkt_cnt0, 3);
    s_valid = 0;

    // ch1 full must not stall ch0
    m1_ready = 0;
    beat(1, 1, 1, 8'hb1);
    beat(1, 1, 1, 8'hb2);
    s_valid = 1; s_sel = 0; s_last = 1; s_data = 8'hc1;
    #1 chk("iso_s_ready", s_ready, 1);
    step();
    chk("iso_m0_valid", {m0_valid, m0_data}, {1'b1, 8'hc1});
    m1_ready = 1;
    beat(0, 0, 0, 0);
    beat(0, 0, 0, 0);

    // counter wrap
    rst = 1; beat(0, 0, 0, 0); rst = 0;
    for (int i = 0; i < 17; i++) beat(1, 0, 1, 8'(i));
    chk("wrap_cnt0", pkt_cnt0, 1);
    beat(0, 0, 0, 0);

    // reset in the middle of a packet
    m0_ready = 0;
    beat(1, 0, 0, 8'hd1);
    beat(1, 0, 0, 8'hd2);
    rst = 1; beat(0, 0, 0, 0); rst = 0;
    chk("mid_m0_valid", m0_valid, 0);
    chk("mid_busy", busy, 0);
    beat(1, 1, 1, 8'he1);
    chk("mid_m1", {m1_valid, m1_data}, {1'b1, 8'he1});
    m0_ready = 1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      m0_ready = $urandom_range(0, 2) != 0;
      m1_ready = $urandom_range(0, 2) != 0;
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, 8'($urandom));
    end
    rst = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
